// File: rtl/piece_move_ctl.sv
// piece_move_ctl
// Chess-board move controller. Holds the 64-square board, runs the local
// pick/place interaction with the mouse, reports each completed local move
// through a valid/ready handshake and applies moves received from a remote
// peer.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   mouse_position[5:0]        square under the cursor (row*8 + col, row 0 top)
//   pick_piece, place_piece    single-cycle requests from the UI
//   draw_square[5:0]           renderer query; draw_piece[3:0] answers 1 cycle later
//   held_valid, held_piece     piece currently in hand
//   move_valid/src/dst/captured, move_ready   local move report handshake
//   rx_move_valid/src/dst, rx_move_ready      remote move input handshake
//   turn                       side to move (0 white, 1 black)
//
// Piece code: 0 empty, bit3 colour (1 black), bits2:0 type
//   (1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king).
//
// Build option PIECE_MOVE_TURN_CHECK_EN: when defined, only the side to move
// may pick, and turn toggles on every local or remote move. When undefined,
// any occupied square is pickable and turn stays 0.
//
// state  | meaning
// IDLE   | waiting for a pick or a remote move
// PICK   | one cycle, loads the piece in hand from the source square
// HOLD   | piece in hand, waiting for a legal place
// PLACE  | one cycle, writes the board and latches the move report
// REPORT | move report presented until accepted

module piece_move_ctl #(
   parameter bit CANCEL_ON_SRC = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] mouse_position,
   input  logic       pick_piece,
   input  logic       place_piece,
   input  logic [5:0] draw_square,
   output logic [3:0] draw_piece,
   output logic       held_valid,
   output logic [3:0] held_piece,
   output logic       move_valid,
   output logic [5:0] move_src,
   output logic [5:0] move_dst,
   output logic [3:0] move_captured,
   input  logic       move_ready,
   input  logic       rx_move_valid,
   input  logic [5:0] rx_src,
   input  logic [5:0] rx_dst,
   output logic       rx_move_ready,
   output logic       turn
);

   typedef enum logic [2:0] {
      S_IDLE, S_PICK, S_HOLD, S_PLACE, S_REPORT
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_board [64];
   logic [5:0] r_src;
   logic [5:0] r_dst;
   logic [3:0] r_held_piece;
   logic [5:0] r_move_src;
   logic [5:0] r_move_dst;
   logic [3:0] r_move_captured;
   logic [3:0] r_draw_piece;

   logic [3:0] w_mouse_code;
   logic       w_turn_ok;
   logic       w_rx_fire;
   logic       w_pick_fire;
   logic       w_cancel;
   logic       w_same_colour;
   logic       w_place_go;

   function automatic logic [3:0] start_code(input logic [5:0] sq);
      logic [2:0] back_type;
      case (sq[2:0])
         3'd0, 3'd7: back_type = 3'd4;
         3'd1, 3'd6: back_type = 3'd2;
         3'd2, 3'd5: back_type = 3'd3;
         3'd3:       back_type = 3'd5;
         default:    back_type = 3'd6;
      endcase
      case (sq[5:3])
         3'd0:    start_code = {1'b1, back_type};
         3'd1:    start_code = 4'h9;
         3'd6:    start_code = 4'h1;
         3'd7:    start_code = {1'b0, back_type};
         default: start_code = 4'h0;
      endcase
   endfunction

   assign w_mouse_code  = r_board[mouse_position];
   assign w_rx_fire     = rx_move_valid && (r_state == S_IDLE);
   // A remote move wins over a simultaneous pick; the pick is simply dropped.
   assign w_pick_fire   = (r_state == S_IDLE) && !rx_move_valid && pick_piece &&
                          (w_mouse_code != 4'h0) && w_turn_ok;
   assign w_cancel      = CANCEL_ON_SRC && (mouse_position == r_src);
   assign w_same_colour = (w_mouse_code != 4'h0) && (w_mouse_code[3] == r_held_piece[3]);
   assign w_place_go    = (r_state == S_HOLD) && place_piece && !w_cancel && !w_same_colour;

`ifdef PIECE_MOVE_TURN_CHECK_EN
   logic r_turn;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_turn <= 1'b0;
      else if (w_rx_fire || (r_state == S_PLACE))
         r_turn <= ~r_turn;
   end
   assign turn      = r_turn;
   assign w_turn_ok = (w_mouse_code[3] == r_turn);
`else
   assign turn      = 1'b0;
   assign w_turn_ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_pick_fire) w_state_nxt = S_PICK;
         S_PICK:   w_state_nxt = S_HOLD;
         S_HOLD: begin
            if (place_piece) begin
               if (w_cancel)
                  w_state_nxt = S_IDLE;
               else if (!w_same_colour)
                  w_state_nxt = S_PLACE;
            end
         end
         S_PLACE:  w_state_nxt = S_REPORT;
         S_REPORT: if (move_ready) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Board reset reloads the start position, so any move in flight is lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 64; i++)
            r_board[i] <= start_code(6'(i));
      end else if (w_rx_fire) begin
         // src == dst must leave the square intact, so skip the clear.
         if (rx_src != rx_dst) begin
            r_board[rx_dst] <= r_board[rx_src];
            r_board[rx_src] <= 4'h0;
         end
      end else if (r_state == S_PLACE) begin
         r_board[r_dst] <= r_held_piece;
         r_board[r_src] <= 4'h0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_src           <= 6'd0;
         r_dst           <= 6'd0;
         r_held_piece    <= 4'h0;
         r_move_src      <= 6'd0;
         r_move_dst      <= 6'd0;
         r_move_captured <= 4'h0;
         r_draw_piece    <= 4'h0;
      end else begin
         r_draw_piece <= r_board[draw_square];
         if (w_pick_fire)
            r_src <= mouse_position;
         if (r_state == S_PICK)
            r_held_piece <= r_board[r_src];
         if (w_place_go)
            r_dst <= mouse_position;
         if (r_state == S_PLACE) begin
            r_move_src      <= r_src;
            r_move_dst      <= r_dst;
            r_move_captured <= r_board[r_dst];
         end
      end
   end

   assign draw_piece    = r_draw_piece;
   assign held_valid    = (r_state == S_HOLD);
   assign held_piece    = r_held_piece;
   assign move_valid    = (r_state == S_REPORT);
   assign move_src      = r_move_src;
   assign move_dst      = r_move_dst;
   assign move_captured = r_move_captured;
   assign rx_move_ready = (r_state == S_IDLE);

endmodule

// File: tb/tb_piece_move_ctl.sv
module tb_piece_move_ctl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] mouse_position = '0;
   logic       pick_piece = 1'b0;
   logic       place_piece = 1'b0;
   logic [5:0] draw_square = '0;
   logic [3:0] draw_piece;
   logic       held_valid;
   logic [3:0] held_piece;
   logic       move_valid;
   logic [5:0] move_src;
   logic [5:0] move_dst;
   logic [3:0] move_captured;
   logic       move_ready = 1'b0;
   logic       rx_move_valid = 1'b0;
   logic [5:0] rx_src = '0;
   logic [5:0] rx_dst = '0;
   logic       rx_move_ready;
   logic       turn;

   always #5 clk = ~clk;

   piece_move_ctl dut (
      .clk(clk), .rst_n(rst_n), .mouse_position(mouse_position),
      .pick_piece(pick_piece), .place_piece(place_piece),
      .draw_square(draw_square), .draw_piece(draw_piece),
      .held_valid(held_valid), .held_piece(held_piece),
      .move_valid(move_valid), .move_src(move_src), .move_dst(move_dst),
      .move_captured(move_captured), .move_ready(move_ready),
      .rx_move_valid(rx_move_valid), .rx_src(rx_src), .rx_dst(rx_dst),
      .rx_move_ready(rx_move_ready), .turn(turn)
   );

   int n_checks = 0;
   int n_errors = 0;

   // reference model: board contents plus "is a piece in hand" bookkeeping
   logic [3:0] m_board [64];
   bit         m_holding;
   int         m_src;
   logic [3:0] m_held;
   bit         m_turn;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] start_piece(input int sq);
      int back [8] = '{4, 2, 3, 5, 6, 3, 2, 4};
      int row = sq / 8;
      int col = sq % 8;
      if (row == 0) return 4'(8 + back[col]);
      if (row == 1) return 4'h9;
      if (row == 6) return 4'h1;
      if (row == 7) return 4'(back[col]);
      return 4'h0;
   endfunction

   function automatic bit side_ok(input logic [3:0] code);
`ifdef PIECE_MOVE_TURN_CHECK_EN
      return code[3] == m_turn;
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) m_board[i] = start_piece(i);
      m_holding = 0;
      m_turn    = 0;
      m_held    = 4'h0;
   endtask

   task automatic model_toggle_turn();
`ifdef PIECE_MOVE_TURN_CHECK_EN
      m_turn = ~m_turn;
`endif
   endtask

   task automatic sweep();
      for (int sq = 0; sq < 64; sq++) begin
         draw_square = 6'(sq);
         tick();
         check_val($sformatf("draw[%0d]", sq), 32'(draw_piece), 32'(m_board[sq]));
      end
   endtask

   task automatic do_pick(input int sq);
      bit acc;
      acc = !m_holding && (m_board[sq] != 4'h0) && side_ok(m_board[sq]);
      mouse_position = 6'(sq);
      pick_piece = 1'b1;
      tick();
      pick_piece = 1'b0;
      tick();
      if (acc) begin
         m_holding = 1;
         m_src     = sq;
         m_held    = m_board[sq];
      end
      check_val("pick_held_valid", 32'(held_valid), 32'(m_holding));
      if (m_holding) check_val("pick_held_piece", 32'(held_piece), 32'(m_held));
   endtask

   task automatic do_place(input int sq, input int wait_cycles, input bit abort);
      logic [3:0] cap;
      mouse_position = 6'(sq);
      place_piece = 1'b1;
      if (!m_holding) begin
         tick();
         place_piece = 1'b0;
         tick();
         check_val("idle_place_held", 32'(held_valid), 32'd0);
         check_val("idle_place_move", 32'(move_valid), 32'd0);
      end else if (sq == m_src) begin
         tick();
         place_piece = 1'b0;
         check_val("cancel_held", 32'(held_valid), 32'd0);
         tick();
         check_val("cancel_move", 32'(move_valid), 32'd0);
         m_holding = 0;
      end else if (m_board[sq] != 4'h0 && m_board[sq][3] == m_held[3]) begin
         tick();
         place_piece = 1'b0;
         check_val("reject_held", 32'(held_valid), 32'd1);
         tick();
         check_val("reject_held2", 32'(held_valid), 32'd1);
      end else begin
         cap = m_board[sq];
         tick();
         place_piece = 1'b0;
         tick();
         m_board[sq]    = m_held;
         m_board[m_src] = 4'h0;
         m_holding      = 0;
         model_toggle_turn();
         for (int i = 0; i <= wait_cycles; i++) begin
            check_val("rep_valid", 32'(move_valid), 32'd1);
            check_val("rep_src", 32'(move_src), 32'(m_src));
            check_val("rep_dst", 32'(move_dst), 32'(sq));
            check_val("rep_cap", 32'(move_captured), 32'(cap));
            check_val("rep_held", 32'(held_valid), 32'd0);
            if (abort) begin
               rst_n = 1'b0;
               #2;
               check_val("abort_move_valid", 32'(move_valid), 32'd0);
               check_val("abort_move_src", 32'(move_src), 32'd0);
               check_val("abort_turn", 32'(turn), 32'd0);
               model_reset();
               tick();
               rst_n = 1'b1;
               return;
            end
            if (i < wait_cycles) tick();
         end
         move_ready = 1'b1;
         tick();
         move_ready = 1'b0;
         check_val("rep_done", 32'(move_valid), 32'd0);
         check_val("turn", 32'(turn), 32'(m_turn));
      end
   endtask

   task automatic do_remote(input int s, input int d, input bit with_pick, input int psq);
      rx_src = 6'(s);
      rx_dst = 6'(d);
      rx_move_valid = 1'b1;
      if (m_holding) begin
         check_val("rx_ready_busy", 32'(rx_move_ready), 32'd0);
         tick();
         rx_move_valid = 1'b0;
         check_val("rx_busy_held", 32'(held_valid), 32'd1);
         return;
      end
      check_val("rx_ready_idle", 32'(rx_move_ready), 32'd1);
      mouse_position = 6'(psq);
      pick_piece = with_pick;
      tick();
      rx_move_valid = 1'b0;
      pick_piece = 1'b0;
      if (s != d) begin
         m_board[d] = m_board[s];
         m_board[s] = 4'h0;
      end
      model_toggle_turn();
      tick();
      check_val("rx_held", 32'(held_valid), 32'd0);
      check_val("rx_ready_after", 32'(rx_move_ready), 32'd1);
      check_val("turn", 32'(turn), 32'(m_turn));
   endtask

   function automatic int rand_occupied();
      int sq;
      for (int t = 0; t < 64; t++) begin
         sq = int'($urandom_range(0, 63));
         if (m_board[sq] != 4'h0) return sq;
      end
      return int'($urandom_range(0, 63));
   endfunction

   initial begin
      int op;
      int sq;
      model_reset();
      #12;
      check_val("rst_held_valid", 32'(held_valid), 32'd0);
      check_val("rst_held_piece", 32'(held_piece), 32'd0);
      check_val("rst_move_valid", 32'(move_valid), 32'd0);
      check_val("rst_move_dst", 32'(move_dst), 32'd0);
      check_val("rst_move_cap", 32'(move_captured), 32'd0);
      check_val("rst_draw", 32'(draw_piece), 32'd0);
      check_val("rst_turn", 32'(turn), 32'd0);
      tick();
      rst_n = 1'b1;
      sweep();

`ifdef PIECE_MOVE_TURN_CHECK_EN
      do_pick(12);
`endif
      // hold a piece, try to drop on own piece, then cancel on source
      do_pick(60);
      do_place(52, 0, 0);
      do_place(60, 0, 0);
      // remote move with a simultaneous pick
      do_remote(12, 28, 1, 52);
      do_remote(28, 28, 0, 0);
      do_pick(52);
      do_place(36, 5, 0);
`ifdef PIECE_MOVE_TURN_CHECK_EN
      do_pick(12);
      do_place(12, 0, 0);
`endif
      sweep();
      // reset while the report is pending
      do_pick(51);
      do_place(35, 2, 1);
      sweep();

      for (int n = 0; n < 300; n++) begin
         op = int'($urandom_range(0, 9));
         if (!m_holding) begin
            if (op < 5)      do_pick(rand_occupied());
            else if (op < 7) begin
               sq = rand_occupied();
               do_remote(sq, ($urandom_range(0, 4) == 0) ? sq : int'($urandom_range(0, 63)),
                         bit'($urandom_range(0, 1)), rand_occupied());
            end
            else if (op < 8) do_place(int'($urandom_range(0, 63)), 0, 0);
            else             do_pick(int'($urandom_range(0, 63)));
         end else begin
            if (op < 6)
               do_place(($urandom_range(0, 4) == 0) ? m_src : int'($urandom_range(0, 63)),
                        int'($urandom_range(0, 3)), 0);
            else if (op < 8) do_pick(int'($urandom_range(0, 63)));
            else             do_remote(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 0, 0);
         end
         if (n % 25 == 24) sweep();
      end
      if (m_holding) do_place(m_src, 0, 0);
      sweep();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/piece_move_ctl.md
PIECE_MOVE_CTL -- requirements
Module: piece_move_ctl

Interface
REQ-001 SHALL have parameter CANCEL_ON_SRC, default 1, meaning that placing on the source square cancels the move.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 SHALL have port mouse_position  input  6  board square under cursor, index = row*8 + col, row 0 at the top.
REQ-005 SHALL have port pick_piece  input  1  single-cycle pick request.
REQ-006 SHALL have port place_piece  input  1  single-cycle place request.
REQ-007 SHALL have port draw_square  input  6  square index queried by the renderer.
REQ-008 SHALL have port draw_piece  output  4  registered piece code of draw_square.
REQ-009 SHALL have port held_valid  output  1  a piece is in hand.
REQ-010 SHALL have port held_piece  output  4  code of the piece in hand.
REQ-011 SHALL have port move_valid, move_src[5:0], move_dst[5:0] and move_captured[3:0] as outputs; together they form the local move report.
REQ-012 SHALL have port move_ready  input  1  the report consumer accepts the report.
REQ-013 SHALL have ports rx_move_valid (input 1), rx_src (input 6), rx_dst (input 6) and rx_move_ready (output 1); together they form the remote move input.
REQ-014 SHALL have port turn  output  1  side to move: 0 = white, 1 = black.

Function
REQ-015 SHALL encode each piece in 4 bits: 0 = empty; bit3 = colour (1 = black); bits2:0 = piece type (1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king).
REQ-016 SHALL hold a 64x4 board array, with draw_piece = board[draw_square] delayed by exactly 1 cycle.
REQ-017 SHALL implement the states IDLE, PICK, HOLD, PLACE and REPORT.
REQ-018 In IDLE, pick_piece on a non-empty square SHALL latch src = mouse_position and go to PICK. pick_piece on an empty square SHALL be ignored.
REQ-019 PICK SHALL last exactly 1 cycle. It loads held_piece = board[src], then goes to HOLD.
REQ-020 held_valid SHALL be 1 in HOLD only.
REQ-021 In HOLD, place_piece SHALL be handled as follows:
- dst == src with CANCEL_ON_SRC = 1: go to IDLE, board unchanged, no report.
- dst occupied by a piece of the same colour as held_piece: stay in HOLD (rejected).
- otherwise: go to PLACE.
REQ-022 PLACE SHALL last exactly 1 cycle and, in the same edge:
- write board[dst] = held_piece;
- write board[src] = 0;
- latch move_captured = old board[dst].
It then goes to REPORT.
REQ-023 In REPORT, move_valid SHALL be 1 and move_src/move_dst/move_captured SHALL be stable. On move_valid & move_ready the block SHALL go to IDLE on the next edge.
REQ-024 pick_piece and place_piece SHALL be ignored in every state other than the one that consumes them. A simultaneous pick and place SHALL be resolved by the current state alone.
REQ-025 rx_move_ready SHALL be 1 only in IDLE. On rx_move_valid & rx_move_ready, the block SHALL, in one cycle, set board[rx_dst] = board[rx_src] and board[rx_src] = 0, and SHALL stay in IDLE.
REQ-026 In IDLE, a remote move SHALL take priority over a simultaneous pick_piece, which is dropped.
REQ-027 A remote move with rx_src == rx_dst SHALL be accepted and SHALL leave the board unchanged.

Reset
REQ-028 rst_n low SHALL immediately force:
- state = IDLE;
- held_valid = 0, held_piece = 0;
- move_valid = 0, move_src = 0, move_dst = 0, move_captured = 0;
- draw_piece = 0;
- turn = 0.
REQ-029 While rst_n is low, the board SHALL load the standard start position:
- row 0: black 4,2,3,5,6,3,2,4 (codes 8+type);
- row 1: black pawns 4'h9;
- row 6: white pawns 4'h1;
- row 7: white 4,2,3,5,6,3,2,4;
- all other squares 0.
REQ-030 Reset asserted mid-move (PICK, HOLD, PLACE or REPORT) SHALL discard the move with no partial board write surviving.

Configuration
REQ-031 With PIECE_MOVE_TURN_CHECK_EN defined, pick_piece SHALL be accepted only when bit3 of the piece equals turn. turn SHALL toggle on every PLACE and every accepted remote move.
REQ-032 Without PIECE_MOVE_TURN_CHECK_EN, any non-empty square SHALL be pickable and turn SHALL be held at 0.

Verification
REQ-033 Reset release, then draw_square sweeps 0..63 -> draw_piece matches REQ-029 (e.g. square 4 = 4'hE, square 52 = 4'h1, square 36 = 4'h0).
REQ-034 Pick at 52, place at 36, move_ready held 0 for 5 cycles -> move_valid = 1, src = 52, dst = 36, captured = 0 held stable; after ready, board[36] = 4'h1 and board[52] = 0.
REQ-035 Pick at 60, place at 52 -> stays in HOLD with held_valid = 1; then place at 60 -> IDLE, no move_valid, board unchanged.
REQ-036 Same-cycle rx_move_valid (12->28) and pick at 52 in IDLE -> remote move applied, pick dropped, held_valid = 0.
REQ-037 With PIECE_MOVE_TURN_CHECK_EN defined, pick at 12 while turn = 0 -> ignored; after a white move, turn = 1 and pick at 12 is accepted.
REQ-038 rst_n pulled low during REPORT -> move_valid = 0 immediately and the board returns to the start position.
